csr_bank: RTL and testbench
===========================

// Module: csr_bank
// PURPOSE
//  Parametrised M-mode CSR bank, successor to the single-hart fixed-width CSR file.
//  - Supports CSRRW/CSRRS/CSRRC write ops and WARL masking.
//  - Provides atomic hardware trap-entry and MRET updates.
//  - Counters have configurable width; read-only CSRs are checked.
//  - Generates a registered, prioritised interrupt request.
//  Sits between the EXU CSR path and the CLINT/trap logic.
// PARAMETERS
//  XLEN    64  CSR data width (32 or 64)
//  CNT_W   64  mcycle/minstret counter width (<=XLEN; read zero-extended)
//  HART_ID 0   constant returned by mhartid (0xF14)
//  MISA    64'h8000_0000_0014_1100  constant returned by misa (0x301)
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     async reset, active low
//  i_cpu_csr_wen   in   1     CPU CSR write enable
//  i_cpu_csr_op    in   2     00=write, 01=set, 10=clear, 11=reserved (treated as write)
//  i_cpu_csr_raddr in   12    read address
//  i_cpu_csr_waddr in   12    write address
//  i_cpu_csr_wdata in   XLEN  write operand
//  o_cpu_csr_rdata out  XLEN  combinational read data, forwarded
//  o_cpu_csr_illeg out  1     comb: waddr unimplemented or read-only, while wen=1
//  i_trap_valid    in   1     trap-entry pulse
//  i_trap_cause    in   XLEN  cause to record
//  i_trap_pc       in   XLEN  pc to record
//  i_trap_tval     in   XLEN  tval to record
//  i_mret          in   1     MRET pulse
//  i_instret       in   1     instruction-retired pulse
//  i_timer_int     in   1     MTIP source
//  i_soft_int      in   1     MSIP source
//  i_ext_int       in   1     MEIP source
//  o_mtvec         out  XLEN  mtvec
//  o_mepc          out  XLEN  mepc
//  o_mstatus       out  XLEN  mstatus
//  o_int_req       out  1     registered interrupt request
//  o_int_cause     out  XLEN  {1'b1, code}; valid while o_int_req=1
// BEHAVIOUR
//  Reset values
//  - mstatus: MPP=11, MPIE=1, all other bits 0.
//  - All other storage: 0. o_int_req=0, o_int_cause=0.
//  CPU write
//  - new = op==01 ? old|wdata : op==10 ? old&~wdata : wdata.
//  - The result is masked by the per-CSR WARL mask, then registered on the next clk edge.
//  WARL masks
//  - mstatus: MIE[3], MPIE[7] and MPP[12:11] writable; MPP is forced to 11.
//  - mie: bits 3, 7, 11.
//  - mtvec: MODE[1:0] takes only 00 or 01 (10/11 are stored as 00).
//  - mepc: bits [1:0] are forced to 0.
//  - mscratch, mcause, mtval, mcycle, minstret: full width.
//  Read-only / illegal writes
//  - misa, mhartid and mip: write ignored, o_cpu_csr_illeg=1.
//  - Unimplemented address: write ignored, o_cpu_csr_illeg=1. Reads of it return 0.
//  Read forwarding
//  - If wen=1 and raddr==waddr on a writable CSR, rdata = masked new value.
//  Trap entry (i_trap_valid)
//  - Same edge: mepc<=pc&~3, mcause<=cause, mtval<=tval.
//  - Same edge: MPIE<=MIE, MIE<=0, MPP<=11.
//  MRET (i_mret)
//  - MIE<=MPIE, MPIE<=1, MPP<=11.
//  Priority, same cycle
//  - trap > mret > CPU write. The losing CPU write is dropped entirely.
//  - Trap and mret together: the trap wins and the mret is ignored.
//  Counters
//  - mcycle += 1 every cycle. minstret += 1 when i_instret=1.
//  - Both wrap modulo 2^CNT_W.
//  - A CPU write to a counter in the same cycle overrides the increment: value = written data.
//  mip
//  - bit7 <= i_timer_int, bit3 <= i_soft_int, bit11 <= i_ext_int, sampled each edge (1-cycle latency).
//  Interrupt request (registered)
//  - o_int_req <= MIE & |(mie & mip). o_int_req is 0 in a cycle with i_trap_valid=1.
//  - o_int_cause code priority: 11 (MEI) > 3 (MSI) > 7 (MTI).
//  - Latency: source input -> o_int_req is 2 edges.
//  Reset
//  - rst_n low mid-operation clears all state immediately (asynchronous).
// CONFIGURATION
//  CSR_MCOUNTINHIBIT_EN defined
//  - Adds mcountinhibit (0x320), writable bits 0 (CY) and 2 (IR); reset value 0.
//  - CY=1 freezes mcycle; IR=1 freezes minstret. A CPU write to a frozen counter still applies.
//  CSR_MCOUNTINHIBIT_EN undefined
//  - 0x320 is unimplemented: reads return 0 and writes set o_cpu_csr_illeg.
//  - Counters always run.
// TESTING
//  1 Reset, then read 0x300 -> 0x1880. mcycle read 5 cycles later = 5 (±1 per sampling edge).
//  2 Write 0x305 with 0x8000_0003 -> reads back 0x8000_0000. Set op on 0x304, data 0x80 -> mie=0x80.
//  3 MIE=1, mie=0x888, ext+timer raised together -> o_int_req=1 after 2 edges, cause=0x8000..000B.
//  4 Trap with pc=0x8000_0102, cause=7, plus a same-cycle CPU write to mepc -> mepc=0x8000_0100, MIE=0, MPIE=old MIE.
//  5 MRET with MPIE=1 -> MIE=1, MPIE=1. Write 0xF14 -> o_cpu_csr_illeg=1, mhartid unchanged = HART_ID.
//  6 mcycle written with all-ones, then one idle cycle -> mcycle=0 (wrap).
//    With the macro: mcountinhibit=1 -> mcycle holds value while minstret counts.

Source files
------------

// File: rtl/csr_bank_if.sv
// CPU-side CSR access bus for csr_bank. Signal names carry the direction
// as seen by the CSR bank (slave): i_* flow into the bank, o_* flow out.
interface csr_bank_if #(
  parameter int XLEN = 64
) ();
  logic            i_cpu_csr_wen;
  logic [1:0]      i_cpu_csr_op;
  logic [11:0]     i_cpu_csr_raddr;
  logic [11:0]     i_cpu_csr_waddr;
  logic [XLEN-1:0] i_cpu_csr_wdata;
  logic [XLEN-1:0] o_cpu_csr_rdata;
  logic            o_cpu_csr_illeg;

  modport master (
    output i_cpu_csr_wen, i_cpu_csr_op, i_cpu_csr_raddr, i_cpu_csr_waddr, i_cpu_csr_wdata,
    input  o_cpu_csr_rdata, o_cpu_csr_illeg
  );

  modport slave (
    input  i_cpu_csr_wen, i_cpu_csr_op, i_cpu_csr_raddr, i_cpu_csr_waddr, i_cpu_csr_wdata,
    output o_cpu_csr_rdata, o_cpu_csr_illeg
  );
endinterface

// File: rtl/csr_bank.sv
// csr_bank: parametrised M-mode CSR bank.
// CPU read/write/set/clear with WARL masking and same-cycle read forwarding,
// atomic trap-entry and MRET updates, free-running counters, sampled mip and
// a registered, prioritised interrupt request.
// Optional feature macro: CSR_MCOUNTINHIBIT_EN adds mcountinhibit (0x320).
module csr_bank #(
  parameter int          XLEN    = 64,
  parameter int          CNT_W   = 64,
  parameter int          HART_ID = 0,
  parameter logic [63:0] MISA    = 64'h8000_0000_0014_1100
) (
  input  logic            clk,
  input  logic            rst_n,
  csr_bank_if.slave       cpu_if,
  input  logic            i_trap_valid,
  input  logic [XLEN-1:0] i_trap_cause,
  input  logic [XLEN-1:0] i_trap_pc,
  input  logic [XLEN-1:0] i_trap_tval,
  input  logic            i_mret,
  input  logic            i_instret,
  input  logic            i_timer_int,
  input  logic            i_soft_int,
  input  logic            i_ext_int,
  output logic [XLEN-1:0] o_mtvec,
  output logic [XLEN-1:0] o_mepc,
  output logic [XLEN-1:0] o_mstatus,
  output logic            o_int_req,
  output logic [XLEN-1:0] o_int_cause
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MINSTRET = 12'hB02;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef CSR_MCOUNTINHIBIT_EN
  localparam logic [11:0] A_MCOUNTINH = 12'h320;
`endif

  localparam logic [XLEN-1:0] MSTATUS_WMASK = XLEN'(64'h88);
  localparam logic [XLEN-1:0] MSTATUS_MPP   = XLEN'(64'h1800);
  localparam logic [XLEN-1:0] MIE_WMASK     = XLEN'(64'h888);
  localparam logic [XLEN-1:0] ALIGN_MASK    = ~XLEN'(64'h3);

  // Architectural state (MPP is hard-wired to M-mode, so it needs no storage)
  logic            r_mstatus_mie;
  logic            r_mstatus_mpie;
  logic [XLEN-1:0] r_mie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [XLEN-1:0] r_mtval;
  logic [XLEN-1:0] r_mip;
  logic [CNT_W-1:0] r_mcycle;
  logic [CNT_W-1:0] r_minstret;
  logic            r_int_req;
  logic [XLEN-1:0] r_int_cause;

  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mip_in;
  logic [XLEN-1:0] w_new_raw;
  logic [XLEN-1:0] w_new;
  logic            w_cpu_we;
  logic            w_inh_cy;
  logic            w_inh_ir;
  logic [XLEN-1:0] w_pending;
  logic [3:0]      w_int_code;
  logic            w_int_next;

`ifdef CSR_MCOUNTINHIBIT_EN
  logic [2:0] r_mcountinhibit;
  assign w_inh_cy = r_mcountinhibit[0];
  assign w_inh_ir = r_mcountinhibit[2];
`else
  assign w_inh_cy = 1'b0;
  assign w_inh_ir = 1'b0;
`endif

  assign w_mstatus = XLEN'({2'b11, 3'b000, r_mstatus_mpie, 3'b000, r_mstatus_mie, 3'b000});
  assign w_mip_in  = XLEN'({i_ext_int, 3'b000, i_timer_int, 3'b000, i_soft_int, 3'b000});

  // Port 0 decodes the read address, port 1 decodes the write address
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [11:0]     w_addr;
      logic [XLEN-1:0] w_val;
      logic            w_impl;
      logic            w_ro;
      logic            w_writable;

      assign w_addr     = (gi == 0) ? cpu_if.i_cpu_csr_raddr : cpu_if.i_cpu_csr_waddr;
      assign w_writable = w_impl & ~w_ro;

      // Current value and access class of the decoded CSR; unknown reads as 0
      always_comb begin
        w_val  = '0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        case (w_addr)
          A_MSTATUS:  w_val = w_mstatus;
          A_MISA:     begin w_val = MISA[XLEN-1:0];  w_ro = 1'b1; end
          A_MIE:      w_val = r_mie;
          A_MTVEC:    w_val = r_mtvec;
          A_MSCRATCH: w_val = r_mscratch;
          A_MEPC:     w_val = r_mepc;
          A_MCAUSE:   w_val = r_mcause;
          A_MTVAL:    w_val = r_mtval;
          A_MIP:      begin w_val = r_mip;           w_ro = 1'b1; end
          A_MCYCLE:   w_val = XLEN'(r_mcycle);
          A_MINSTRET: w_val = XLEN'(r_minstret);
          A_MHARTID:  begin w_val = XLEN'(HART_ID);  w_ro = 1'b1; end
`ifdef CSR_MCOUNTINHIBIT_EN
          A_MCOUNTINH: w_val = XLEN'(r_mcountinhibit);
`endif
          default:    w_impl = 1'b0;
        endcase
      end
    end
  endgenerate

  // Apply the write op to the old value, then the target CSR's WARL mask
  always_comb begin
    case (cpu_if.i_cpu_csr_op)
      2'b01:   w_new_raw = g_port[1].w_val | cpu_if.i_cpu_csr_wdata;
      2'b10:   w_new_raw = g_port[1].w_val & ~cpu_if.i_cpu_csr_wdata;
      default: w_new_raw = cpu_if.i_cpu_csr_wdata;
    endcase
    w_new = w_new_raw;
    case (cpu_if.i_cpu_csr_waddr)
      A_MSTATUS:  w_new = (w_new_raw & MSTATUS_WMASK) | MSTATUS_MPP;
      A_MIE:      w_new = w_new_raw & MIE_WMASK;
      A_MTVEC:    w_new = w_new_raw[1] ? (w_new_raw & ALIGN_MASK) : w_new_raw;
      A_MEPC:     w_new = w_new_raw & ALIGN_MASK;
      A_MCYCLE,
      A_MINSTRET: w_new = XLEN'(w_new_raw[CNT_W-1:0]);
`ifdef CSR_MCOUNTINHIBIT_EN
      A_MCOUNTINH: w_new = w_new_raw & XLEN'(64'h5);
`endif
      default:    w_new = w_new_raw;
    endcase
  end

  // A CPU write commits only when neither a trap nor an MRET claims the cycle
  assign w_cpu_we = cpu_if.i_cpu_csr_wen & g_port[1].w_writable & ~i_trap_valid & ~i_mret;

  assign cpu_if.o_cpu_csr_illeg = cpu_if.i_cpu_csr_wen & ~g_port[1].w_writable;
  assign cpu_if.o_cpu_csr_rdata =
      (cpu_if.i_cpu_csr_wen && g_port[0].w_writable &&
       (cpu_if.i_cpu_csr_raddr == cpu_if.i_cpu_csr_waddr)) ? w_new : g_port[0].w_val;

  // mstatus: trap entry beats MRET beats CPU write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b1;
    end else if (i_trap_valid) begin
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (i_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_cpu_we && cpu_if.i_cpu_csr_waddr == A_MSTATUS) begin
      r_mstatus_mie  <= w_new[3];
      r_mstatus_mpie <= w_new[7];
    end
  end

  // Trap-recorded CSRs: hardware capture on trap, otherwise CPU writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
    end else if (i_trap_valid) begin
      r_mepc   <= i_trap_pc & ALIGN_MASK;
      r_mcause <= i_trap_cause;
      r_mtval  <= i_trap_tval;
    end else if (w_cpu_we) begin
      if (cpu_if.i_cpu_csr_waddr == A_MEPC)   r_mepc   <= w_new;
      if (cpu_if.i_cpu_csr_waddr == A_MCAUSE) r_mcause <= w_new;
      if (cpu_if.i_cpu_csr_waddr == A_MTVAL)  r_mtval  <= w_new;
    end
  end

  // Plain software-only CSRs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie      <= '0;
      r_mtvec    <= '0;
      r_mscratch <= '0;
    end else if (w_cpu_we) begin
      if (cpu_if.i_cpu_csr_waddr == A_MIE)      r_mie      <= w_new;
      if (cpu_if.i_cpu_csr_waddr == A_MTVEC)    r_mtvec    <= w_new;
      if (cpu_if.i_cpu_csr_waddr == A_MSCRATCH) r_mscratch <= w_new;
    end
  end

`ifdef CSR_MCOUNTINHIBIT_EN
  // Counter inhibit bits (CY, IR)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcountinhibit <= '0;
    end else if (w_cpu_we && cpu_if.i_cpu_csr_waddr == A_MCOUNTINH) begin
      r_mcountinhibit <= w_new[2:0];
    end
  end
`endif

  // Counters: a CPU write overrides the increment; otherwise wrap modulo 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      if (w_cpu_we && cpu_if.i_cpu_csr_waddr == A_MCYCLE) begin
        r_mcycle <= w_new[CNT_W-1:0];
      end else if (!w_inh_cy) begin
        r_mcycle <= r_mcycle + CNT_W'(1);
      end
      if (w_cpu_we && cpu_if.i_cpu_csr_waddr == A_MINSTRET) begin
        r_minstret <= w_new[CNT_W-1:0];
      end else if (!w_inh_ir) begin
        r_minstret <= r_minstret + CNT_W'(i_instret);
      end
    end
  end

  // Pending interrupts by priority: external > software > timer
  assign w_pending  = r_mie & r_mip;
  assign w_int_next = ~i_trap_valid & r_mstatus_mie & (|w_pending);
  always_comb begin
    w_int_code = 4'd7;
    if (w_pending[11])     w_int_code = 4'd11;
    else if (w_pending[3]) w_int_code = 4'd3;
  end

  // mip sampling and the registered interrupt request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mip       <= '0;
      r_int_req   <= 1'b0;
      r_int_cause <= '0;
    end else begin
      r_mip       <= w_mip_in;
      r_int_req   <= w_int_next;
      r_int_cause <= w_int_next ? {1'b1, (XLEN-1)'(w_int_code)} : '0;
    end
  end

  assign o_mtvec     = r_mtvec;
  assign o_mepc      = r_mepc;
  assign o_mstatus   = w_mstatus;
  assign o_int_req   = r_int_req;
  assign o_int_cause = r_int_cause;

endmodule

// File: tb/tb_csr_bank.sv
// Randomised + directed bench for csr_bank with an architectural model and
// a scoreboard queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_csr_bank;
  localparam int          XLEN    = 64;
  localparam int          CNT_W   = 48;
  localparam int          HART_ID = 3;
  localparam logic [63:0] MISA    = 64'h8000_0000_0014_1100;
  localparam logic [63:0] CNT_MASK = (64'd1 << CNT_W) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_valid, mret, instret, timer_int, soft_int, ext_int;
  logic [63:0] trap_cause, trap_pc, trap_tval;
  logic [63:0] o_mtvec, o_mepc, o_mstatus, o_int_cause;
  logic        o_int_req;

  csr_bank_if #(.XLEN(XLEN)) u_if ();

  csr_bank #(.XLEN(XLEN), .CNT_W(CNT_W), .HART_ID(HART_ID), .MISA(MISA)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_if(u_if),
    .i_trap_valid(trap_valid), .i_trap_cause(trap_cause), .i_trap_pc(trap_pc),
    .i_trap_tval(trap_tval), .i_mret(mret), .i_instret(instret),
    .i_timer_int(timer_int), .i_soft_int(soft_int), .i_ext_int(ext_int),
    .o_mtvec(o_mtvec), .o_mepc(o_mepc), .o_mstatus(o_mstatus),
    .o_int_req(o_int_req), .o_int_cause(o_int_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    int          raddr;
    logic [63:0] rdata;
    logic        illeg;
    logic [63:0] mstatus, mepc, mtvec;
    logic        int_req;
    logic [63:0] int_cause;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   txn_id = 0;

  // Architectural model: writable CSRs live in an associative array by address
  logic [63:0] csr[int];
  logic [63:0] m_mip, m_cause;
  bit          m_req;

  // Stimulus for the next cycle
  bit          d_wen, d_trap, d_mret, d_instret, d_tim, d_soft, d_ext;
  bit [1:0]    d_op;
  int          d_raddr, d_waddr;
  logic [63:0] d_wdata, d_cause, d_pc, d_tval;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    csr.delete();
    csr['h300] = 64'h1880;
    csr['h304] = 0; csr['h305] = 0; csr['h340] = 0; csr['h341] = 0;
    csr['h342] = 0; csr['h343] = 0; csr['hB00] = 0; csr['hB02] = 0;
`ifdef CSR_MCOUNTINHIBIT_EN
    csr['h320] = 0;
`endif
    m_mip = 0; m_req = 0; m_cause = 0;
  endfunction

  function automatic logic [63:0] m_read(int a);
    if (a == 'h301) return MISA;
    if (a == 'hF14) return 64'(HART_ID);
    if (a == 'h344) return m_mip;
    if (csr.exists(a)) return csr[a];
    return 64'd0;
  endfunction

  function automatic logic [63:0] warl(int a, logic [63:0] v);
    case (a)
      'h300: return (v & 64'h88) | 64'h1800;
      'h304: return v & 64'h888;
      'h305: return (v[1:0] >= 2'd2) ? (v & ~64'd3) : v;
      'h341: return v & ~64'd3;
      'hB00, 'hB02: return v & CNT_MASK;
      'h320: return v & 64'h5;
      default: return v;
    endcase
  endfunction

  task automatic clr();
    d_wen = 0; d_op = 0; d_raddr = 'h300; d_waddr = 'h300; d_wdata = 0;
    d_trap = 0; d_mret = 0; d_instret = 0; d_cause = 0; d_pc = 0; d_tval = 0;
  endtask

  // Drive one cycle of stimulus, queue the expected response, advance the model
  task automatic apply();
    exp_t        e;
    logic [63:0] old_v, nv, pend, tmp;
    bit          wr_ok, n_req, inh_cy, inh_ir;
    logic [63:0] n_cause;
    u_if.i_cpu_csr_wen   = d_wen;
    u_if.i_cpu_csr_op    = d_op;
    u_if.i_cpu_csr_raddr = 12'(d_raddr);
    u_if.i_cpu_csr_waddr = 12'(d_waddr);
    u_if.i_cpu_csr_wdata = d_wdata;
    trap_valid = d_trap; trap_cause = d_cause; trap_pc = d_pc; trap_tval = d_tval;
    mret = d_mret; instret = d_instret;
    timer_int = d_tim; soft_int = d_soft; ext_int = d_ext;
    #1;
    wr_ok = csr.exists(d_waddr);
    old_v = m_read(d_waddr);
    case (d_op)
      2'd1:    nv = old_v | d_wdata;
      2'd2:    nv = old_v & ~d_wdata;
      default: nv = d_wdata;
    endcase
    nv = warl(d_waddr, nv);
    e.id      = txn_id++;
    e.raddr   = d_raddr;
    e.rdata   = (d_wen && wr_ok && d_raddr == d_waddr) ? nv : m_read(d_raddr);
    e.illeg   = d_wen && !wr_ok;
    e.mstatus = csr['h300];
    e.mepc    = csr['h341];
    e.mtvec   = csr['h305];
    e.int_req = m_req;
    e.int_cause = m_cause;
    sbq.push_back(e);
    // next-state
    pend  = csr['h304] & m_mip;
    tmp   = csr['h300];
    n_req = !d_trap && tmp[3] && (pend != 0);
    n_cause = 0;
    if (n_req) n_cause = 64'h8000_0000_0000_0000 + (pend[11] ? 64'd11 : pend[3] ? 64'd3 : 64'd7);
    inh_cy = 0; inh_ir = 0;
`ifdef CSR_MCOUNTINHIBIT_EN
    tmp = csr['h320]; inh_cy = tmp[0]; inh_ir = tmp[2];
`endif
    if (!inh_cy) csr['hB00] = (csr['hB00] + 64'd1) & CNT_MASK;
    if (!inh_ir && d_instret) csr['hB02] = (csr['hB02] + 64'd1) & CNT_MASK;
    tmp = csr['h300];
    if (d_trap) begin
      csr['h300] = 64'h1800 | (tmp[3] ? 64'h80 : 64'h0);
      csr['h341] = d_pc & ~64'd3;
      csr['h342] = d_cause;
      csr['h343] = d_tval;
    end else if (d_mret) begin
      csr['h300] = 64'h1880 | (tmp[7] ? 64'h8 : 64'h0);
    end else if (d_wen && wr_ok) begin
      csr[d_waddr] = nv;
    end
    m_mip   = ({63'd0, d_ext} << 11) | ({63'd0, d_tim} << 7) | ({63'd0, d_soft} << 3);
    m_req   = n_req;
    m_cause = n_cause;
  endtask

  task automatic step();
    @(negedge clk);
    apply();
  endtask

  // Monitor: every cycle the DUT presents a response, compare it to the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("rdata",     u_if.o_cpu_csr_rdata, e.rdata);
        chk("illeg",     64'(u_if.o_cpu_csr_illeg), 64'(e.illeg));
        chk("mstatus",   o_mstatus, e.mstatus);
        chk("mepc",      o_mepc, e.mepc);
        chk("mtvec",     o_mtvec, e.mtvec);
        chk("int_req",   64'(o_int_req), 64'(e.int_req));
        chk("int_cause", o_int_cause, e.int_cause);
        $display("txn %0d raddr=%03h rdata=%h illeg=%0b int_req=%0b",
                 e.id, e.raddr, u_if.o_cpu_csr_rdata, u_if.o_cpu_csr_illeg, o_int_req);
      end
    end
  end

  int addr_tbl[16] = '{'h300, 'h301, 'h304, 'h305, 'h340, 'h341, 'h342, 'h343,
                       'h344, 'hB00, 'hB02, 'hF14, 'h320, 'h7C0, 'h000, 'hFFF};

  initial begin
    clr(); d_tim = 0; d_soft = 0; d_ext = 0;
    u_if.i_cpu_csr_wen = 0; u_if.i_cpu_csr_op = 0; u_if.i_cpu_csr_raddr = 0;
    u_if.i_cpu_csr_waddr = 0; u_if.i_cpu_csr_wdata = 0;
    trap_valid = 0; mret = 0; instret = 0; timer_int = 0; soft_int = 0; ext_int = 0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    m_reset();
    repeat (3) @(negedge clk);

    // 1: reset values, mcycle after 5 cycles
    rst_n = 1'b1;
    apply();
    #1 chk("reset_mstatus_read", u_if.o_cpu_csr_rdata, 64'h1880);
    repeat (4) step();
    d_raddr = 'hB00; step();
    #1 chk("mcycle_after_5", u_if.o_cpu_csr_rdata, 64'd5);

    // 2: mtvec WARL with forwarding, then set op on mie
    clr(); d_wen = 1; d_waddr = 'h305; d_raddr = 'h305; d_wdata = 64'h8000_0003; step();
    #1 chk("mtvec_fwd", u_if.o_cpu_csr_rdata, 64'h8000_0000);
    clr(); d_raddr = 'h305; step();
    #1 chk("mtvec_read", u_if.o_cpu_csr_rdata, 64'h8000_0000);
    clr(); d_wen = 1; d_op = 2'b01; d_waddr = 'h304; d_wdata = 64'h80; step();
    clr(); d_raddr = 'h304; step();
    #1 chk("mie_set", u_if.o_cpu_csr_rdata, 64'h80);

    // 3: interrupt latency and priority
    clr(); d_wen = 1; d_waddr = 'h300; d_wdata = 64'h8; step();
    clr(); d_wen = 1; d_waddr = 'h304; d_wdata = 64'h888; step();
    clr(); d_ext = 1; d_tim = 1; step();
    clr(); step();
    #1 chk("int_req_1edge", 64'(o_int_req), 64'd0);
    clr(); step();
    #1 chk("int_req_2edge", 64'(o_int_req), 64'd1);
    chk("int_cause_mei", o_int_cause, 64'h8000_0000_0000_000B);

    // 4: trap beats a same-cycle mepc write
    clr(); d_trap = 1; d_pc = 64'h8000_0102; d_cause = 64'd7; d_tval = 64'h55;
    d_wen = 1; d_waddr = 'h341; d_wdata = 64'h1234; step();
    clr(); d_raddr = 'h342; step();
    #1 chk("trap_mepc", o_mepc, 64'h8000_0100);
    chk("trap_mstatus", o_mstatus, 64'h1880);
    chk("trap_int_req", 64'(o_int_req), 64'd0);

    // 5: MRET, read-only mhartid
    clr(); d_mret = 1; step();
    clr(); d_wen = 1; d_waddr = 'hF14; d_raddr = 'hF14; d_wdata = 64'hDEAD; step();
    #1 chk("mret_mstatus", o_mstatus, 64'h1888);
    chk("mhartid_illeg", 64'(u_if.o_cpu_csr_illeg), 64'd1);
    chk("mhartid_val", u_if.o_cpu_csr_rdata, 64'(HART_ID));
    d_ext = 0; d_tim = 0;

    // 6: counter wrap
    clr(); d_wen = 1; d_waddr = 'hB00; d_wdata = '1; step();
    clr(); step();
    clr(); d_raddr = 'hB00; step();
    #1 chk("mcycle_wrap", u_if.o_cpu_csr_rdata, 64'd0);
`ifdef CSR_MCOUNTINHIBIT_EN
    clr(); d_wen = 1; d_waddr = 'h320; d_wdata = 64'h1; step();
    for (int i = 0; i < 6; i++) begin
      clr(); d_instret = 1; d_raddr = (i % 2 == 0) ? 'hB00 : 'hB02; step();
    end
    clr(); d_wen = 1; d_waddr = 'h320; d_wdata = 64'h0; step();
`endif

    // Asynchronous reset in the middle of a cycle
    clr(); d_wen = 1; d_waddr = 'h340; d_wdata = 64'hABCD; step();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("arst_mstatus", o_mstatus, 64'h1880);
    chk("arst_mepc", o_mepc, 64'd0);
    chk("arst_mtvec", o_mtvec, 64'd0);
    chk("arst_int_req", 64'(o_int_req), 64'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clr(); d_raddr = 'h340;
    apply();

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      clr();
      d_wen   = ($urandom_range(0, 1) == 1);
      d_op    = 2'($urandom_range(0, 3));
      d_waddr = addr_tbl[$urandom_range(0, 15)];
      d_raddr = ($urandom_range(0, 3) == 0) ? d_waddr : addr_tbl[$urandom_range(0, 15)];
      case ($urandom_range(0, 3))
        0: d_wdata = '1;
        1: d_wdata = 64'($urandom_range(0, 15)) << ($urandom_range(0, 3) * 4);
        default: d_wdata = {$urandom, $urandom};
      endcase
      d_trap    = ($urandom_range(0, 15) == 0);
      d_mret    = ($urandom_range(0, 11) == 0);
      d_instret = ($urandom_range(0, 1) == 1);
      d_pc = {$urandom, $urandom}; d_cause = {$urandom, $urandom}; d_tval = {$urandom, $urandom};
      if (i % 8 == 0) begin
        d_tim = ($urandom_range(0, 1) == 1);
        d_soft = ($urandom_range(0, 1) == 1);
        d_ext = ($urandom_range(0, 2) == 0);
      end
      step();
    end

    #5;
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
